// File: rtl/tdm_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tdm_scan_ctrl                                                  |
// | Function : TDM scan controller. Steps an 8:1 selector / 1:8 distributor  |
// |            pair and reassembles the serial bits into a received word.    |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tdm_scan_ctrl #(
   parameter int HOLD_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       iStart,
   input  logic [7:0] iData,
   output logic [7:0] oTxData,
   output logic       A,
   output logic       B,
   output logic       C,
   input  logic [7:0] iF,
   output logic [7:0] oData,
   output logic       oBusy,
   output logic       oDone,
   output logic       oMatch
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] c_holdLast = 4'(HOLD_CYCLES - 1);

   state_t     r_state;
   logic [2:0] r_sel;
   logic [3:0] r_holdCnt;
   logic [7:0] r_shadow;
   logic [7:0] r_txData;
   logic [7:0] r_rxData;
   logic       r_busy;
   logic       r_done;
   logic       r_match;

   logic       w_holdEnd;
   logic [7:0] w_captured;

   assign w_holdEnd = (r_holdCnt == c_holdLast);

   // Shadow word as it will look once the currently selected bit is captured.
   always_comb begin
      w_captured        = r_shadow;
      w_captured[r_sel] = iF[r_sel];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_sel     <= 3'd0;
         r_holdCnt <= 4'd0;
         r_shadow  <= 8'd0;
         r_txData  <= 8'd0;
         r_rxData  <= 8'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_match   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (iStart) begin
                  r_txData  <= iData;
                  r_sel     <= 3'd0;
                  r_holdCnt <= 4'd0;
                  r_shadow  <= 8'd0;
                  r_busy    <= 1'b1;
                  r_state   <= SCAN;
               end else begin
                  r_busy    <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            SCAN: begin
               if (w_holdEnd) begin
                  r_shadow <= w_captured;
                  if (r_sel == 3'd7) begin
                     // Select code stays at 7 so the counter never wraps in SCAN.
                     r_rxData <= w_captured;
                     r_match  <= (w_captured == r_txData);
                     r_done   <= 1'b1;
                     r_busy   <= 1'b0;
                     r_state  <= DONE;
                  end else begin
                     r_sel     <= r_sel + 3'd1;
                     r_holdCnt <= 4'd0;
                  end
               end else begin
                  r_holdCnt <= r_holdCnt + 4'd1;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign oTxData = r_txData;
   assign A       = r_sel[2];
   assign B       = r_sel[1];
   assign C       = r_sel[0];
   assign oData   = r_rxData;
   assign oBusy   = r_busy;
   assign oDone   = r_done;
   assign oMatch  = r_match;

endmodule
`default_nettype wire
